// File: rtl/ysyx_22051013_ifu_fetch_pkg.sv
// Shared constants for the NPC instruction fetch unit.
package ysyx_22051013_ifu_fetch_pkg;

   localparam int          XLEN_DEFAULT     = 64;
   localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
   localparam int          INST_W           = 32;
   localparam logic [31:0] NOP              = 32'h0000_0013;
   localparam logic        RSTABLE          = 1'b1;

endpackage : ysyx_22051013_ifu_fetch_pkg

// File: rtl/ysyx_22051013_ifu_pc.sv
// Architectural fetch PC register and its next-PC mux (redirect / pc+4 / hold).
module ysyx_22051013_ifu_pc
   import ysyx_22051013_ifu_fetch_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] PC_RESET = XLEN'(PC_RESET_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   input  logic            i_advance,
   output logic [XLEN-1:0] o_pc
);

   // Jump targets are forced onto a 4-byte boundary.
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_next;

   // Next-PC selection: redirect wins over sequential advance; otherwise hold.
   always_comb begin
      // NOTE: default assigned first so every path drives w_pc_next and no latch is inferred.
      w_pc_next = r_pc;
      if (i_redirect_valid) begin
         w_pc_next = i_redirect_pc & ALIGN_MASK;
      end else if (i_advance) begin
         w_pc_next = r_pc + XLEN'(4);
      end
   end

   // PC register, asynchronously reset to the boot address.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         r_pc <= PC_RESET;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   assign o_pc = r_pc;

endmodule : ysyx_22051013_ifu_pc

// File: rtl/ysyx_22051013_ifu_fetch.sv
// Instruction fetch: one outstanding imem request, single instruction buffer,
// valid/ready hand-off to decode, redirect kills wrong-path fetches.
module ysyx_22051013_ifu_fetch
   import ysyx_22051013_ifu_fetch_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] PC_RESET = XLEN'(PC_RESET_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_resp_valid,
   input  logic [INST_W-1:0] imem_resp_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_e;

   fetch_state_e      r_state;
   fetch_state_e      w_state_next;
   logic              r_drop;
   logic              w_drop_next;
   logic [INST_W-1:0] r_inst;
   logic              w_capture;
   logic              w_req_fire;
   logic              w_out_fire;
   logic [XLEN-1:0]   w_pc;

   assign w_req_fire = (r_state == S_REQ) && imem_req_ready;
   // A redirect in the same cycle suppresses the hand-off of a wrong-path instruction.
   assign out_valid  = (r_state == S_HOLD) && !redirect_valid;
   assign w_out_fire = out_valid && out_ready;

   ysyx_22051013_ifu_pc #(
      .XLEN     (XLEN),
      .PC_RESET (PC_RESET)
   ) u_pc (
      .clk              (clk),
      .rst              (rst),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .i_advance        (w_out_fire),
      .o_pc             (w_pc)
   );

   // Next-state, drop-flag and buffer-capture decisions; redirect has priority.
   always_comb begin
      w_state_next = r_state;
      w_drop_next  = r_drop;
      w_capture    = 1'b0;
      case (r_state)
         S_IDLE: w_state_next = S_REQ;
         S_REQ: begin
            if (w_req_fire) begin
               w_state_next = S_WAIT;
               // A request accepted alongside a redirect is already wrong-path.
               w_drop_next  = redirect_valid;
            end
         end
         S_WAIT: begin
            if (imem_resp_valid) begin
               w_drop_next = 1'b0;
               if (r_drop || redirect_valid) begin
                  w_state_next = S_REQ;
               end else begin
                  w_state_next = S_HOLD;
                  w_capture    = 1'b1;
               end
            end else if (redirect_valid) begin
               w_drop_next = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect_valid || w_out_fire) begin
               w_state_next = S_REQ;
            end
         end
      endcase
   end

   // FSM state, drop flag and instruction buffer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_drop  <= 1'b0;
         r_inst  <= NOP;
      end else begin
         r_state <= w_state_next;
         r_drop  <= w_drop_next;
         if (w_capture) begin
            r_inst <= imem_resp_data;
         end
      end
   end

   assign imem_req_valid = (r_state == S_REQ);
   assign imem_req_addr  = w_pc;
   assign out_pc         = w_pc;
   assign out_inst       = r_inst;

endmodule : ysyx_22051013_ifu_fetch

// File: tb/tb_ysyx_22051013_ifu_fetch.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch unit.
module tb_ysyx_22051013_ifu_fetch;

   localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_W  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_inst;

   always #5 clk = ~clk;

   ysyx_22051013_ifu_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_inst        (out_inst)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: architectural pc, last buffered instruction, and flags for
   // "fetch started", "a request is outstanding", "it is wrong-path", "buffer full".
   logic [63:0] m_pc;
   logic [31:0] m_inst;
   bit          m_started, m_out, m_wrong, m_full;

   // Memory model: one pending response with a countdown.
   bit          mem_busy;
   int          mem_delay;
   logic [63:0] mem_addr;
   logic [31:0] mem_salt;

   // Stimulus knobs for the next cycle.
   bit          k_redir, k_oready, k_rready, k_force;
   logic [63:0] k_rpc;
   int          k_lat;

   // Samples of the DUT outputs taken in the last step.
   logic        s_req, s_ov;
   logic [63:0] s_addr, s_pc;
   logic [31:0] s_inst;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      case (a)
         64'h0000_0000_8000_0000: return 32'h0000_0513;
         64'h0000_0000_8000_0004: return 32'h0010_0073;
         default:                 return a[31:0] ^ 32'h1357_9BDF;
      endcase
   endfunction

   task automatic model_reset();
      m_pc      = PC_RST;
      m_inst    = NOP_W;
      m_started = 0;
      m_out     = 0;
      m_wrong   = 0;
      m_full    = 0;
      mem_busy  = 0;
      mem_delay = 0;
   endtask

   // One clock cycle: called at a negedge, drives inputs, compares outputs
   // against the model, advances the model at the posedge, returns at the next negedge.
   task automatic step();
      bit          exp_req, mem_fire, rv, hs_req, hs_out, resp;
      logic [31:0] rdata;
      redirect_valid  = k_redir;
      redirect_pc     = k_rpc;
      out_ready       = k_oready;
      imem_req_ready  = k_rready;
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      mem_fire        = 0;
      if (mem_busy) begin
         if (mem_delay == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_addr) ^ mem_salt;
            mem_fire        = 1;
         end else begin
            mem_delay--;
         end
      end else if (k_force) begin
         imem_resp_valid = 1'b1;
      end
      #1;
      s_req  = imem_req_valid;
      s_addr = imem_req_addr;
      s_ov   = out_valid;
      s_pc   = out_pc;
      s_inst = out_inst;
      exp_req = m_started && !m_out && !m_full;
      check("req_valid", s_req, exp_req);
      check("req_addr", s_addr, m_pc);
      check("out_valid", s_ov, m_full && !k_redir);
      check("out_pc", s_pc, m_pc);
      check("out_inst", s_inst, m_inst);
      @(posedge clk);
      rv     = k_redir;
      hs_req = exp_req && k_rready;
      hs_out = m_full && !rv && k_oready;
      resp   = imem_resp_valid;
      rdata  = imem_resp_data;
      if (rv || hs_out) m_full = 0;
      if (hs_req) begin
         m_out     = 1;
         m_wrong   = rv;
         mem_busy  = 1;
         mem_delay = k_lat;
         mem_addr  = m_pc;
      end else if (m_out && resp) begin
         if (!m_wrong && !rv) begin
            m_full = 1;
            m_inst = rdata;
         end
         m_out   = 0;
         m_wrong = 0;
      end else if (m_out && rv) begin
         m_wrong = 1;
      end
      if (mem_fire) mem_busy = 0;
      if (rv) m_pc = {k_rpc[63:2], 2'b00};
      else if (hs_out) m_pc = m_pc + 64'd4;
      m_started = 1;
      k_redir   = 0;
      k_force   = 0;
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, imem_req_valid, 1'b0);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_req_addr"}, imem_req_addr, PC_RST);
      check({tag, "_out_pc"}, out_pc, PC_RST);
      check({tag, "_out_inst"}, out_inst, NOP_W);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      redirect_valid = 0; redirect_pc = '0; imem_req_ready = 0;
      imem_resp_valid = 0; imem_resp_data = '0; out_ready = 0;
      k_redir = 0; k_rpc = '0; k_oready = 1; k_rready = 1; k_lat = 0; k_force = 0;
      mem_salt = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Zero-wait memory, decode always ready: one instruction every 3 cycles.
      step(); check("t1_idle_req", s_req, 1'b0);
      step(); check("t1_first_req", s_req, 1'b1); check("t1_first_addr", s_addr, 64'h8000_0000);
      step(); check("t1_wait_ov", s_ov, 1'b0);
      step(); check("t1_ov0", s_ov, 1'b1); check("t1_pc0", s_pc, 64'h8000_0000);
      check("t1_inst0", s_inst, 32'h0000_0513);
      step(); check("t1_ov_gap", s_ov, 1'b0); check("t1_addr1", s_addr, 64'h8000_0004);
      step();
      step(); check("t1_ov1", s_ov, 1'b1); check("t1_pc1", s_pc, 64'h8000_0004);
      check("t1_inst1", s_inst, 32'h0010_0073);

      // Back-pressure in HOLD for 5 cycles.
      step(); check("t2_req", s_req, 1'b1);
      step();
      k_oready = 0;
      repeat (5) begin
         step();
         check("t2_hold_ov", s_ov, 1'b1);
         check("t2_hold_pc", s_pc, 64'h8000_0008);
         check("t2_hold_inst", s_inst, 32'h9357_9BD7);
         check("t2_hold_noreq", s_req, 1'b0);
      end
      k_oready = 1;
      step(); check("t2_release_ov", s_ov, 1'b1);
      k_lat = 3;
      step(); check("t2_next_addr", s_addr, 64'h8000_000C); check("t2_next_req", s_req, 1'b1);

      // Redirect while the response is 3 cycles late: response dropped.
      k_lat = 0; k_redir = 1; k_rpc = 64'h8000_0100;
      step(); check("t3_ov", s_ov, 1'b0);
      repeat (3) begin
         step(); check("t3_wait_ov", s_ov, 1'b0); check("t3_wait_req", s_req, 1'b0);
      end
      step(); check("t3_req", s_req, 1'b1); check("t3_addr", s_addr, 64'h8000_0100);
      step();
      step(); check("t3_ov_target", s_ov, 1'b1); check("t3_pc_target", s_pc, 64'h8000_0100);

      // Redirect coincident with the response in WAIT.
      step(); check("t4_addr_seq", s_addr, 64'h8000_0104);
      k_redir = 1; k_rpc = 64'h8000_0400;
      step(); check("t4_ov", s_ov, 1'b0);
      step(); check("t4_req", s_req, 1'b1); check("t4_addr", s_addr, 64'h8000_0400);
      step();

      // Redirect in HOLD with decode ready: no hand-off, unaligned target.
      k_redir = 1; k_rpc = 64'h8000_0202;
      step(); check("t5_ov_gated", s_ov, 1'b0); check("t4_delivered", s_inst, 32'h9357_9FDF);
      step(); check("t5_req", s_req, 1'b1); check("t5_addr", s_addr, 64'h8000_0200);
      step();
      k_redir = 1; k_rpc = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      step(); check("wrap_addr_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      step();
      step(); check("wrap_ov", s_ov, 1'b1);
      k_lat = 3;
      step(); check("wrap_addr_zero", s_addr, 64'h0);

      // Asynchronous reset while a response is pending.
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      k_lat = 0; k_force = 1;
      step(); check("t6_idle_req", s_req, 1'b0);
      step(); check("t6_req", s_req, 1'b1); check("t6_addr", s_addr, 64'h8000_0000);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         k_redir  = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 2))
            0:       k_rpc = {$urandom, $urandom};
            1:       k_rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            default: k_rpc = 64'h8000_0000 | 64'($urandom_range(0, 4095));
         endcase
         k_oready = ($urandom_range(0, 3) != 0);
         k_rready = ($urandom_range(0, 3) != 0);
         k_lat    = $urandom_range(0, 3);
         k_force  = !mem_busy && ($urandom_range(0, 15) == 0);
         mem_salt = $urandom;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_ysyx_22051013_ifu_fetch
